// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vga_pkg                                                |
// | Description : Shared VGA 640x480@60 timing constants, coordinate     |
// |               width and a window-compare helper.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package vga_pkg;

  // Coordinate width shared with the graphics stage
  localparam int COORD_W   = 10;

  // System clocks per pixel (100 MHz -> 25 MHz)
  localparam int DIV       = 4;

  // Horizontal timing, in pixels
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  // Vertical timing, in lines
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // True when lo <= val <= hi
  function automatic logic in_window(input logic [COORD_W-1:0] val,
                                     input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pixel_tick_gen                                         |
// | Description : Mod-DIV divider; p_tick is high one clk in every DIV.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int DIV = vga_pkg::DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("pixel_tick_gen: DIV must be at least 2");
    end
  endgenerate

  logic [c_cnt_w-1:0] div_cnt_q;
  logic [c_cnt_w-1:0] div_cnt_d;

  // Next divider count: wrap at DIV-1
  always_comb begin
    div_cnt_d = div_cnt_q + c_cnt_w'(1);
    if (div_cnt_q == c_last) begin
      div_cnt_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign p_tick = (div_cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vga_sync                                               |
// | Description : VGA scan counters and registered hsync/vsync. Sync     |
// |               registers are loaded from next-state counts so they    |
// |               line up with pixel_x/pixel_y in every cycle.           |
// |               Optional macro VGA_SYNC_FRAME_TICK_EN adds f_tick, a   |
// |               one-clk pulse at the start of vertical blanking.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vga_sync
  import vga_pkg::*;
#(
  parameter int DIV       = vga_pkg::DIV,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
`ifdef VGA_SYNC_FRAME_TICK_EN
  output logic               f_tick,
`endif
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y
);

  localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] c_h_last = COORD_W'(c_h_total - 1);
  localparam logic [COORD_W-1:0] c_v_last = COORD_W'(c_v_total - 1);
  localparam logic [COORD_W-1:0] c_h_disp = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] c_v_disp = COORD_W'(V_DISPLAY);

  // Sync windows, inclusive
  localparam int c_hs_lo = H_DISPLAY + H_FRONT;
  localparam int c_hs_hi = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int c_vs_lo = V_DISPLAY + V_FRONT;
  localparam int c_vs_hi = V_DISPLAY + V_FRONT + V_SYNC - 1;

  generate
    if (c_h_total > 1024 || c_v_total > 1024) begin : g_bad_total
      $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [COORD_W-1:0] h_count_q, h_count_d;
  logic [COORD_W-1:0] v_count_q, v_count_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               h_wrap;

  pixel_tick_gen #(
    .DIV    (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Next-state counters and syncs; counters move only on p_tick
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    h_wrap    = 1'b0;
    if (p_tick) begin
      if (h_count_q == c_h_last) begin
        h_count_d = '0;
        h_wrap    = 1'b1;
        if (v_count_q == c_v_last) begin
          v_count_d = '0;
        end else begin
          v_count_d = v_count_q + COORD_W'(1);
        end
      end else begin
        h_count_d = h_count_q + COORD_W'(1);
      end
    end
    hsync_d = !in_window(h_count_d, c_hs_lo, c_hs_hi);
    vsync_d = !in_window(v_count_d, c_vs_lo, c_vs_hi);
  end

  // Counter and sync registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign pixel_x  = h_count_q;
  assign pixel_y  = v_count_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_count_q < c_h_disp) && (v_count_q < c_v_disp);

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic f_tick_q, f_tick_d;

  // Frame tick request: the edge that moves the scan to (0, V_DISPLAY)
  always_comb begin
    f_tick_d = h_wrap && (v_count_d == c_v_disp);
  end

  // Frame tick register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_tick_q <= 1'b0;
    end else begin
      f_tick_q <= f_tick_d;
    end
  end

  assign f_tick = f_tick_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_vga_sync                                            |
// | Description : Directed table-driven bench for vga_sync. Horizontal   |
// |               timing is the real 800-pixel line; vertical timing is  |
// |               shrunk to an 8-line frame (4 visible, sync on 5..6).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_vga_sync;

  localparam int c_line  = 3200;        // clk per line
  localparam int c_frame = 8 * c_line;  // clk per shrunk frame

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync, vsync, video_on, p_tick;
  logic [9:0] pixel_x, pixel_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic       f_tick;
`endif

  vga_sync #(
    .DIV       (4),
    .H_DISPLAY (640),
    .H_FRONT   (16),
    .H_SYNC    (96),
    .H_BACK    (48),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hsync    (hsync),
    .vsync    (vsync),
    .video_on (video_on),
    .p_tick   (p_tick),
`ifdef VGA_SYNC_FRAME_TICK_EN
    .f_tick   (f_tick),
`endif
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] flags;  // {hsync, vsync, video_on, p_tick}
  } vec_t;

  vec_t tbl [18];
  int   n_tbl;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pt_bad   = 0;
  int hs_low   = 0;
  int vs_low   = 0;
  int von_hi   = 0;
  int pt_cnt   = 0;
  bit first_run = 1'b1;
`ifdef VGA_SYNC_FRAME_TICK_EN
  int ft_cnt = 0, ft_first = -1, ft_second = -1;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int c, input int x, input int y, input logic [3:0] f);
    tbl[n_tbl].cyc   = c;
    tbl[n_tbl].x     = 10'(x);
    tbl[n_tbl].y     = 10'(y);
    tbl[n_tbl].flags = f;
    n_tbl++;
  endtask

  // Called at each negedge after reset release
  task automatic sample();
    if (p_tick !== ((cyc % 4) == 3)) pt_bad++;
    if (first_run && cyc < c_frame) begin
      if (!hsync)  hs_low++;
      if (!vsync)  vs_low++;
      if (video_on) von_hi++;
      if (p_tick)  pt_cnt++;
    end
`ifdef VGA_SYNC_FRAME_TICK_EN
    if (first_run && f_tick) begin
      ft_cnt++;
      if (ft_cnt == 1) ft_first = cyc;
      else if (ft_cnt == 2) ft_second = cyc;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sample();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    @(negedge clk);
    sample();
  endtask

  task automatic check_now(input string tag, input int x, input int y, input logic [3:0] f);
    check({tag, ".x"}, int'(pixel_x), x);
    check({tag, ".y"}, int'(pixel_y), y);
    check({tag, ".flags"}, int'({hsync, vsync, video_on, p_tick}), int'(f));
  endtask

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      while (cyc < tbl[i].cyc) step();
      check_now($sformatf("cyc%0d", tbl[i].cyc), int'(tbl[i].x), int'(tbl[i].y), tbl[i].flags);
    end
  endtask

  initial begin
    n_tbl = 0;
    //  cycle          x    y   {hs,vs,von,pt}
    put(0,             0,   0,  4'b1110);
    put(3,             0,   0,  4'b1111);
    put(4,             1,   0,  4'b1110);
    put(2559,          639, 0,  4'b1111);
    put(2560,          640, 0,  4'b1100);
    put(2623,          655, 0,  4'b1101);
    put(2624,          656, 0,  4'b0100);
    put(3007,          751, 0,  4'b0101);
    put(3008,          752, 0,  4'b1100);
    put(3199,          799, 0,  4'b1101);
    put(3200,          0,   1,  4'b1110);
    put(4 * c_line,    0,   4,  4'b1100);
    put(5 * c_line - 1, 799, 4, 4'b1101);
    put(5 * c_line,    0,   5,  4'b1000);
    put(7 * c_line - 1, 799, 6, 4'b1001);
    put(7 * c_line,    0,   7,  4'b1100);
    put(8 * c_line - 1, 799, 7, 4'b1101);
    put(8 * c_line,    0,   0,  4'b1110);

    // Asynchronous reset: values appear with no clock edge
    reset = 1'b1;
    #1;
    check_now("rst_async", 0, 0, 4'b1110);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_now("rst_held", 0, 0, 4'b1110);

    release_reset();
    run_table(0, n_tbl - 1);

    // Mid-frame reset during hsync and vsync low, (700, 5) of frame 2
    while (cyc < c_frame + 5 * c_line + 700 * 4 + 1) step();
    check_now("pre_rst", 700, 5, 4'b0000);
    #2 reset = 1'b1;
    #1;
    check_now("mid_rst", 0, 0, 4'b1110);
    first_run = 1'b0;

    check("ptick_pattern_errors", pt_bad, 0);
    check("hsync_low_clk", hs_low, 8 * 96 * 4);
    check("vsync_low_clk", vs_low, 2 * c_line);
    check("video_on_clk", von_hi, 4 * 640 * 4);
    check("ptick_per_frame", pt_cnt, 8 * 800);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("ftick_count", ft_cnt, 2);
    check("ftick_first", ft_first, 4 * c_line);
    check("ftick_spacing", ft_second - ft_first, c_frame);
`endif

    // After release the line timing repeats from (0,0)
    @(posedge clk);
    release_reset();
    pt_bad = 0;
    run_table(0, 8);
    check("ptick_pattern_after_rst", pt_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
